hdmi_fifo_pixel_reader: RTL

//  Read-side consumer of the 128-in/16-out frame-buffer FIFO in the DDR->HDMI loop. Runs on the pixel clock.

---
 rtl/video_timing_pkg.sv | 34 +++
 rtl/video_timing_gen.sv | 65 ++++++
 rtl/hdmi_fifo_pixel_reader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared defaults, reader state type, per-pixel control bundle and RGB565 expansion for the HDMI read path.
package video_timing_pkg;

  localparam int H_ACTIVE_DEF    = 1280;
  localparam int H_FP_DEF        = 110;
  localparam int H_SYNC_DEF      = 40;
  localparam int H_BP_DEF        = 220;
  localparam int V_ACTIVE_DEF    = 720;
  localparam int V_FP_DEF        = 5;
  localparam int V_SYNC_DEF      = 5;
  localparam int V_BP_DEF        = 20;
  localparam int RD_LATENCY_DEF  = 1;
  localparam int LVL_W_DEF       = 13;
  localparam int PREFILL_LVL_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2
  } rd_state_t;

  // Stage-0 control bits that travel alongside the FIFO read latency.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic popped;
  } pix_ctl_t;

  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters for the pixel reader: stage-0 HS/VS/DE plus frame-wrap and vblank-start strobes.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic de0,
  output logic hs0,
  output logic vs0,
  output logic frame_wrap,
  output logic vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic          h_wrap;

  assign h_wrap = (h_cnt_reg == H_LAST);

  // Held at the origin outside RUN so the first RUN cycle is pixel (0,0).
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_wrap) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    de0          = run && (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    hs0          = run && (h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST);
    vs0          = run && (v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST);
    frame_wrap   = run && h_wrap && (v_cnt_reg == V_LAST);
    vblank_start = run && (h_cnt_reg == '0) && (v_cnt_reg == V_ACT);
  end

endmodule

// File: rtl/hdmi_fifo_pixel_reader.sv
// Pixel-clock consumer of the frame-buffer FIFO: run/prefill control, pixel pops, latency alignment and RGB888 video out.
module hdmi_fifo_pixel_reader
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_ACTIVE    = V_ACTIVE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter logic HS_POL      = 1'b1,
  parameter logic VS_POL      = 1'b1,
  parameter int   RD_LATENCY  = RD_LATENCY_DEF,
  parameter int   LVL_W       = LVL_W_DEF,
  parameter int   PREFILL_LVL = PREFILL_LVL_DEF
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             enable,
  output logic             fifo_rd_en,
  input  logic [15:0]      fifo_rd_data,
  input  logic             fifo_rd_empty,
  input  logic [LVL_W-1:0] fifo_rd_water_level,
  output logic             frame_req,
  output logic             underflow,
  output logic             vid_hs,
  output logic             vid_vs,
  output logic             vid_de,
  output logic [7:0]       vid_r,
  output logic [7:0]       vid_g,
  output logic [7:0]       vid_b
);

  localparam logic [LVL_W-1:0] PREFILL_THR = LVL_W'(PREFILL_LVL);

  rd_state_t state_reg, state_next;
  logic      run;
  logic      fsm_req;
  logic      de0, hs0, vs0;
  logic      frame_wrap, vblank_start;
  pix_ctl_t  ctl0;
  pix_ctl_t  ctl_out;
  pix_ctl_t [RD_LATENCY-1:0] ctl_dly_reg;
  logic [23:0] rgb;

  assign run = (state_reg == RUN);

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (rd_clk),
    .rst          (rd_rst),
    .run          (run),
    .de0          (de0),
    .hs0          (hs0),
    .vs0          (vs0),
    .frame_wrap   (frame_wrap),
    .vblank_start (vblank_start)
  );

  always_ff @(posedge rd_clk) begin
    if (rd_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // enable is only looked at in RUN on the wrap, so a frame is never cut short.
  always_comb begin
    state_next = state_reg;
    fsm_req    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = PREFILL;
          fsm_req    = 1'b1;
        end
      end
      PREFILL: begin
        if (!enable)                                  state_next = IDLE;
        else if (fifo_rd_water_level >= PREFILL_THR)  state_next = RUN;
      end
      RUN: begin
        if (frame_wrap && !enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign frame_req  = !rd_rst && (fsm_req || vblank_start);
  assign fifo_rd_en = de0 && !fifo_rd_empty;

  always_comb begin
    ctl0.hs     = hs0;
    ctl0.vs     = vs0;
    ctl0.de     = de0;
    ctl0.popped = fifo_rd_en;
  end

  // Delay stage-0 control by the FIFO read latency so it lines up with fifo_rd_data.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      ctl_dly_reg <= '0;
    end else begin
      ctl_dly_reg[0] <= ctl0;
      for (int i = 1; i < RD_LATENCY; i++) ctl_dly_reg[i] <= ctl_dly_reg[i-1];
    end
  end

  assign ctl_out = ctl_dly_reg[RD_LATENCY-1];
  assign rgb     = (ctl_out.de && ctl_out.popped) ? rgb565_to_rgb888(fifo_rd_data) : 24'h000000;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      vid_hs    <= ~HS_POL;
      vid_vs    <= ~VS_POL;
      vid_de    <= 1'b0;
      vid_r     <= '0;
      vid_g     <= '0;
      vid_b     <= '0;
      underflow <= 1'b0;
    end else begin
      vid_hs <= ctl_out.hs ? HS_POL : ~HS_POL;
      vid_vs <= ctl_out.vs ? VS_POL : ~VS_POL;
      vid_de <= ctl_out.de;
      vid_r  <= rgb[23:16];
      vid_g  <= rgb[15:8];
      vid_b  <= rgb[7:0];
      if (de0 && fifo_rd_empty) underflow <= 1'b1;
    end
  end

endmodule
